// File: rtl/seat_mem.sv
// Seat-state table with request arbitration, a background expiry sweep,
// a registered read port and a live count of OCCUPIED seats.
module seat_mem #(
    parameter int unsigned N_SEATS = 32,
    parameter int unsigned SEAT_W  = $clog2(N_SEATS),
    parameter int unsigned TIME_W  = 11
) (
    input  logic              clk_seat_mem,
    input  logic              rst_seat_mem,
    input  logic [TIME_W-1:0] cur_time,
    input  logic [TIME_W-1:0] away_limit,
    input  logic [TIME_W-1:0] resv_limit,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEAT_W-1:0] req_seat,
    input  logic [1:0]        req_state,
    output logic              resp_valid,
    output logic              resp_deny,
    input  logic [SEAT_W-1:0] rd_seat,
    output logic [1:0]        rd_state,
    output logic [TIME_W-1:0] rd_time,
    output logic              expire_valid,
    output logic [SEAT_W-1:0] expire_seat,
    output logic [SEAT_W:0]   occupied_cnt
);

    localparam int unsigned CNT_W = SEAT_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_SEATS - 1);
    localparam logic [CNT_W-1:0] SEAT_LIM  = CNT_W'(N_SEATS);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_AWAY  = 2'd1;
    localparam logic [1:0] ST_RESV  = 2'd2;
    localparam logic [1:0] ST_OCC   = 2'd3;

    typedef enum logic {INIT, RUN} fsm_e;

    fsm_e              fsm_q, fsm_d;
    logic [SEAT_W-1:0] init_idx_q, init_idx_d;
    logic [SEAT_W-1:0] sw_ptr_q, sw_ptr_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_deny_q, resp_deny_d;
    logic [1:0]        rd_state_q, rd_state_d;
    logic [TIME_W-1:0] rd_time_q, rd_time_d;
    logic              expire_valid_q, expire_valid_d;
    logic [SEAT_W-1:0] expire_seat_q, expire_seat_d;
    logic [CNT_W-1:0]  occ_cnt_q, occ_cnt_d;

    logic [1:0]        state_mem_q [N_SEATS];
    logic [TIME_W-1:0] time_mem_q  [N_SEATS];

    logic              init_we, req_we, sw_we;
    logic              accept, deny, sw_expire;
    logic              req_in_range, rd_in_range;
    logic [1:0]        req_old, sw_old;
    logic [TIME_W-1:0] elapsed;

    // Request arbitration and sweep evaluation against the current table
    always_comb begin
        req_in_range = ({1'b0, req_seat} < SEAT_LIM);
        rd_in_range  = ({1'b0, rd_seat} < SEAT_LIM);
        req_old      = state_mem_q[req_seat];
        sw_old       = state_mem_q[sw_ptr_q];
        elapsed      = cur_time - time_mem_q[sw_ptr_q];

        accept = req_valid && req_ready_q;
        deny   = !req_in_range
              || (req_state == ST_OCC && req_old == ST_OCC)
              || (req_state == ST_RESV && req_old != ST_EMPTY);
        req_we = accept && !deny;

        sw_expire = (fsm_q == RUN)
                 && ((sw_old == ST_AWAY && elapsed > away_limit)
                  || (sw_old == ST_RESV && elapsed > resv_limit));
        // An accepted request to the swept seat takes priority over expiry
        sw_we = sw_expire && !(accept && req_seat == sw_ptr_q);
    end

    // FSM, pointers and registered outputs
    always_comb begin
        fsm_d          = fsm_q;
        init_idx_d     = init_idx_q;
        sw_ptr_d       = sw_ptr_q;
        init_we        = 1'b0;
        resp_valid_d   = accept;
        resp_deny_d    = accept && deny;
        expire_valid_d = sw_we;
        expire_seat_d  = sw_we ? sw_ptr_q : expire_seat_q;
        occ_cnt_d      = occ_cnt_q;
        rd_state_d     = '0;
        rd_time_d      = '0;

        case (fsm_q)
            INIT: begin
                init_we = 1'b1;
                if ({1'b0, init_idx_q} == LAST_IDX) begin
                    fsm_d      = RUN;
                    init_idx_d = '0;
                end else begin
                    init_idx_d = init_idx_q + SEAT_W'(1);
                end
            end
            RUN: begin
                sw_ptr_d = ({1'b0, sw_ptr_q} == LAST_IDX) ? '0 : sw_ptr_q + SEAT_W'(1);
            end
            default: fsm_d = INIT;
        endcase

        req_ready_d = (fsm_d == RUN);

        if (req_we) begin
            if (req_state == ST_OCC && req_old != ST_OCC && occ_cnt_q != SEAT_LIM) begin
                occ_cnt_d = occ_cnt_q + CNT_W'(1);
            end else if (req_state != ST_OCC && req_old == ST_OCC && occ_cnt_q != '0) begin
                occ_cnt_d = occ_cnt_q - CNT_W'(1);
            end
        end

        // Read port returns the entry as it stands after this cycle's writes
        if (rd_in_range) begin
            rd_state_d = state_mem_q[rd_seat];
            rd_time_d  = time_mem_q[rd_seat];
            if (init_we && init_idx_q == rd_seat) begin
                rd_state_d = ST_EMPTY;
                rd_time_d  = '0;
            end
            if (sw_we && sw_ptr_q == rd_seat) begin
                rd_state_d = ST_EMPTY;
            end
            if (req_we && req_seat == rd_seat) begin
                rd_state_d = req_state;
                rd_time_d  = cur_time;
            end
        end
    end

    always_ff @(posedge clk_seat_mem) begin
        if (rst_seat_mem) begin
            fsm_q          <= INIT;
            init_idx_q     <= '0;
            sw_ptr_q       <= '0;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_deny_q    <= 1'b0;
            rd_state_q     <= '0;
            rd_time_q      <= '0;
            expire_valid_q <= 1'b0;
            expire_seat_q  <= '0;
            occ_cnt_q      <= '0;
        end else begin
            fsm_q          <= fsm_d;
            init_idx_q     <= init_idx_d;
            sw_ptr_q       <= sw_ptr_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_deny_q    <= resp_deny_d;
            rd_state_q     <= rd_state_d;
            rd_time_q      <= rd_time_d;
            expire_valid_q <= expire_valid_d;
            expire_seat_q  <= expire_seat_d;
            occ_cnt_q      <= occ_cnt_d;
        end
    end

    // Table storage; request write is last so it wins on any overlap
    always_ff @(posedge clk_seat_mem) begin
        if (!rst_seat_mem) begin
            if (init_we) begin
                state_mem_q[init_idx_q] <= ST_EMPTY;
                time_mem_q[init_idx_q]  <= '0;
            end
            if (sw_we) begin
                state_mem_q[sw_ptr_q] <= ST_EMPTY;
            end
            if (req_we) begin
                state_mem_q[req_seat] <= req_state;
                time_mem_q[req_seat]  <= cur_time;
            end
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_deny    = resp_deny_q;
    assign rd_state     = rd_state_q;
    assign rd_time      = rd_time_q;
    assign expire_valid = expire_valid_q;
    assign expire_seat  = expire_seat_q;
    assign occupied_cnt = occ_cnt_q;

endmodule

// File: tb/tb_seat_mem.sv
// Directed self-checking bench for seat_mem (32 seats, 11-bit time).
module tb_seat_mem;

    localparam int N  = 32;
    localparam int SW = 5;
    localparam int TW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] cur_time, away_limit, resv_limit;
    logic          req_valid, req_ready;
    logic [SW-1:0] req_seat;
    logic [1:0]    req_state;
    logic          resp_valid, resp_deny;
    logic [SW-1:0] rd_seat;
    logic [1:0]    rd_state;
    logic [TW-1:0] rd_time;
    logic          expire_valid;
    logic [SW-1:0] expire_seat;
    logic [SW:0]   occupied_cnt;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;

    seat_mem #(.N_SEATS(N), .TIME_W(TW)) dut (
        .clk_seat_mem (clk),
        .rst_seat_mem (rst),
        .cur_time     (cur_time),
        .away_limit   (away_limit),
        .resv_limit   (resv_limit),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_seat     (req_seat),
        .req_state    (req_state),
        .resp_valid   (resp_valid),
        .resp_deny    (resp_deny),
        .rd_seat      (rd_seat),
        .rd_state     (rd_state),
        .rd_time      (rd_time),
        .expire_valid (expire_valid),
        .expire_seat  (expire_seat),
        .occupied_cnt (occupied_cnt)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; the sweep pointer is derived from this
    always @(posedge clk) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_req(input int seat, input int st, input int exp_deny, input string tag);
        req_valid = 1'b1;
        req_seat  = SW'(seat);
        req_state = 2'(st);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_valid"}, 32'(resp_valid), 1);
        check({tag, "_deny"}, 32'(resp_deny), 32'(exp_deny));
    endtask

    task automatic rd_check(input int seat, input int exp_st, input int exp_t, input bit chk_t,
                            input string tag);
        rd_seat = SW'(seat);
        @(negedge clk);
        check({tag, "_state"}, 32'(rd_state), 32'(exp_st));
        if (chk_t) check({tag, "_time"}, 32'(rd_time), 32'(exp_t));
    endtask

    task automatic expect_expire(input int seat, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (expire_valid) begin
                seen = 1'b1;
                check(tag, 32'(expire_seat), 32'(seat));
            end
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic expect_no_expire(input int budget, input string tag);
        int hits = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (expire_valid) hits++;
        end
        check(tag, 32'(hits), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 0);
        check({tag, "_resp_deny"}, 32'(resp_deny), 0);
        check({tag, "_exp_valid"}, 32'(expire_valid), 0);
        check({tag, "_exp_seat"}, 32'(expire_seat), 0);
        check({tag, "_occ"}, 32'(occupied_cnt), 0);
        check({tag, "_rd_state"}, 32'(rd_state), 0);
        check({tag, "_rd_time"}, 32'(rd_time), 0);
    endtask

    // Release reset, expect exactly N cycles of req_ready low, then scan a cleared table
    task automatic release_and_scan(input string tag);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            check({tag, "_init_ready"}, 32'(req_ready), 0);
            @(negedge clk);
        end
        check({tag, "_ready_up"}, 32'(req_ready), 1);
        for (int s = 0; s < N; s++) rd_check(s, 0, 0, 1'b1, {tag, "_scan"});
    endtask

    initial begin
        bit found;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_seat   = '0;
        req_state  = '0;
        rd_seat    = '0;
        cur_time   = '0;
        away_limit = TW'(2047);
        resv_limit = TW'(2047);
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        release_and_scan("boot");

        // Occupy seat 5, then double-seating is denied
        cur_time = TW'(100);
        do_req(5, 3, 0, "occ5");
        check("occ5_cnt", 32'(occupied_cnt), 1);
        do_req(5, 3, 1, "dbl5");
        check("dbl5_cnt", 32'(occupied_cnt), 1);
        rd_check(5, 3, 100, 1'b1, "rd5");

        // AWAY expiry across the time wrap: elapsed 20 holds, 21 expires
        away_limit = TW'(20);
        cur_time   = TW'(2040);
        do_req(7, 1, 0, "away7");
        cur_time = TW'(12);
        expect_no_expire(40, "wrap_e20");
        cur_time = TW'(13);
        expect_expire(7, 40, "wrap_e21");
        rd_check(7, 0, 0, 1'b0, "rd7");

        // Reservation rules on seat 3; occupied seats never expire
        resv_limit = TW'(50);
        cur_time   = TW'(0);
        do_req(3, 2, 0, "resv3");
        do_req(3, 2, 1, "resv3_dup");
        cur_time = TW'(10);
        do_req(3, 3, 0, "occ3");
        check("occ3_cnt", 32'(occupied_cnt), 2);
        cur_time = TW'(1000);
        expect_no_expire(40, "occ3_noexp");
        rd_check(3, 3, 10, 1'b1, "rd3");

        // RESERVED expiry boundary: elapsed 50 holds, 51 expires
        cur_time = TW'(500);
        do_req(12, 2, 0, "resv12");
        cur_time = TW'(550);
        expect_no_expire(40, "resv_e50");
        cur_time = TW'(551);
        expect_expire(12, 40, "resv_e51");

        // Request to the swept seat in the very cycle it would expire
        cur_time = TW'(300);
        do_req(9, 1, 0, "away9");
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (((edges - 32) % N) == 9) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) check("phase_timeout", 0, 1);
        cur_time  = TW'(400);
        req_valid = 1'b1;
        req_seat  = SW'(9);
        req_state = 2'd3;
        @(negedge clk);
        req_valid = 1'b0;
        check("coll_valid", 32'(resp_valid), 1);
        check("coll_deny", 32'(resp_deny), 0);
        check("coll_noexp", 32'(expire_valid), 0);
        check("coll_cnt", 32'(occupied_cnt), 3);
        expect_no_expire(40, "coll_later");
        rd_check(9, 3, 400, 1'b1, "rd9");

        // Build up to 4 occupied, with one release and re-occupy on the way
        do_req(20, 3, 0, "occ20");
        check("occ20_cnt", 32'(occupied_cnt), 4);
        do_req(5, 0, 0, "free5");
        check("free5_cnt", 32'(occupied_cnt), 3);
        do_req(5, 3, 0, "reocc5");
        check("reocc5_cnt", 32'(occupied_cnt), 4);

        // Mid-run reset with a request in flight
        rst       = 1'b1;
        req_valid = 1'b1;
        req_seat  = SW'(0);
        req_state = 2'd3;
        rd_seat   = SW'(5);
        @(negedge clk);
        req_valid = 1'b0;
        check_reset_outputs("rst1");
        release_and_scan("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
